debouncer: RTL and testbench
============================

// Module: debouncer
// PURPOSE
//  Cleans a mechanical/asynchronous input (button, switch) into a glitch-free level.
//  - Synchronizes bouncy_in into the clk domain with a 2-flop synchronizer.
//  - Changes the output only after the synchronized input has held a new level for
//    BOUNCE_TICKS consecutive clocks.
//  - Sits between board I/O pins and the control FSMs.
//  - Also provides single-cycle edge pulses of the debounced level.
// PARAMETERS
//  BOUNCE_TICKS  default 10  consecutive stable clk cycles required to accept a new level (>=1)
// PORTS
//  clk            input   1  system clock; all logic on posedge
//  rst            input   1  synchronous, active-high reset
//  bouncy_in      input   1  raw asynchronous input, may bounce at any time
//  debounced_out  output  1  filtered level, registered
//  rise_pulse     output  1  high for exactly 1 cycle when debounced_out goes 0->1
//  fall_pulse     output  1  high for exactly 1 cycle when debounced_out goes 1->0
// BEHAVIOUR
//  Reset:
//  - rst sampled high at a posedge: sync flops=0, state=S_LOW, counter=0,
//    debounced_out=0, rise_pulse=0, fall_pulse=0.
//  - Reset mid-transition discards any partial count. No async reset.
//  Synchronizer:
//  - sync_q = bouncy_in delayed by 2 flops.
//  - Only sync_q feeds the FSM; bouncy_in is never used combinationally.
//  Counter:
//  - Width $clog2(BOUNCE_TICKS+1); saturates, never wraps.
//  FSM (state enum in package):
//  - S_LOW: out=0. sync_q==1 -> S_MAYBE_HIGH, counter=1.
//  - S_MAYBE_HIGH: out=0.
//    - sync_q==0 -> S_LOW, counter=0.
//    - sync_q==1 and counter==BOUNCE_TICKS -> S_HIGH, out=1, rise_pulse=1.
//    - else counter++.
//  - S_HIGH: out=1. sync_q==0 -> S_MAYBE_LOW, counter=1.
//  - S_MAYBE_LOW: out=1.
//    - sync_q==1 -> S_HIGH, counter=0.
//    - sync_q==0 and counter==BOUNCE_TICKS -> S_LOW, out=0, fall_pulse=1.
//    - else counter++.
//  Timing:
//  - debounced_out, rise_pulse and fall_pulse are registered and change on the same edge.
//  - Pulses clear on the next edge.
//  - Latency: bouncy_in stable from posedge N -> debounced_out changes at posedge
//    N+2+BOUNCE_TICKS.
//  - BOUNCE_TICKS=1 gives 3 cycles of latency.
//  Filtering:
//  - Any reversion of sync_q before the count completes returns to the stable state with
//    no output change and no pulse.
//  - Glitches shorter than BOUNCE_TICKS cycles are fully rejected.
//  - Illegal or unreachable state encoding -> S_LOW, out=0.
// STRUCTURE
//  - debouncer_pkg: typedef enum logic [1:0] {S_LOW, S_MAYBE_HIGH, S_HIGH, S_MAYBE_LOW}
//    debounce_state_t.
//  - Sub-module synchronizer #(.STAGES(2)): clk, rst, d, q. Instantiated once for bouncy_in.
//  - Top: FSM + saturating counter + output/pulse registers.
// TESTING (BOUNCE_TICKS=100, clk 12 MHz)
//  1. Reset: rst=1 for 2 cycles with bouncy_in=0.
//     -> debounced_out=0, no pulses; stays 0 for 200 idle cycles.
//  2. Bounce burst: 10-29 random toggles at 1-15 ns spacing, ending in level L, then hold.
//     -> exactly one transition to L, 102 cycles after the last toggle; out otherwise unchanged.
//  3. Clean rise: 0->1 held.
//     -> out=1 at edge N+102; rise_pulse high for only that cycle; fall_pulse stays 0.
//  4. Glitch: 1 for 99 cycles, then 0.
//     -> out stays 0, no pulse. Repeat from high with 99-cycle low: out stays 1.
//  5. Reset mid-count: input high for 50 cycles, rst for 1 cycle, input kept high.
//     -> out rises 102 cycles after rst deasserts.
//  6. Fall: from out=1, input 1->0 held.
//     -> out=0 at N+102 with a single fall_pulse.
//     Check with BOUNCE_TICKS=1: latency of 3.

Source files
------------

// File: rtl/debouncer_pkg.sv
// Shared types and helpers for the debouncer: FSM state encoding and the
// output level implied by each state.
package debouncer_pkg;

  typedef enum logic [1:0] {
    S_LOW        = 2'b00,
    S_MAYBE_HIGH = 2'b01,
    S_HIGH       = 2'b10,
    S_MAYBE_LOW  = 2'b11
  } debounce_state_t;

  localparam int unsigned SYNC_STAGES = 2;

  // Debounced level held while sitting in a given state; unknown codes read as low.
  function automatic logic state_level(input debounce_state_t s);
    logic lvl;
    case (s)
      S_LOW:        lvl = 1'b0;
      S_MAYBE_HIGH: lvl = 1'b0;
      S_HIGH:       lvl = 1'b1;
      S_MAYBE_LOW:  lvl = 1'b1;
      default:      lvl = 1'b0;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/debouncer_checker.sv
// Property checks on the debouncer outputs and counter range; bound in by the
// debouncer itself so every instance carries them.
module debouncer_checker #(
  parameter int CNT_W   = 4,
  parameter int CNT_MAX = 10
) (
  input logic             clk,
  input logic             rst,
  input logic             debounced_out,
  input logic             rise_pulse,
  input logic             fall_pulse,
  input logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(CNT_MAX);

  logic seen_reset_r;

  // Gates history-based checks until outputs have been reset at least once.
  always_ff @(posedge clk) begin
    if (rst) begin
      seen_reset_r <= 1'b1;
    end else begin
      seen_reset_r <= seen_reset_r;
    end
  end

  a_pulses_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(rise_pulse && fall_pulse));

  a_rise_means_high: assert property (@(posedge clk) disable iff (rst)
    rise_pulse |-> debounced_out);

  a_fall_means_low: assert property (@(posedge clk) disable iff (rst)
    fall_pulse |-> !debounced_out);

  a_change_has_pulse: assert property (@(posedge clk) disable iff (rst)
    (seen_reset_r && !$past(rst) && (debounced_out != $past(debounced_out)))
      |-> (rise_pulse || fall_pulse));

  a_count_in_range: assert property (@(posedge clk) disable iff (rst)
    cnt <= CNT_LIMIT);

endmodule

// File: rtl/debouncer_synchronizer.sv
// Multi-flop synchronizer bringing an asynchronous level into the clk domain.
// STAGES must be at least 2.
module debouncer_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_r;

  // Shift chain; the first flop is the only one that may go metastable.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
    end
  end

  assign q = sync_r[STAGES-1];

endmodule

// File: rtl/debouncer.sv
// Debounces a raw pin into a clean registered level and emits one-cycle
// rise/fall pulses whenever that level changes.
module debouncer
  import debouncer_pkg::*;
#(
  parameter int BOUNCE_TICKS = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic bouncy_in,
  output logic debounced_out,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int               CNT_W   = $clog2(BOUNCE_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BOUNCE_TICKS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic            sync_q_s;
  debounce_state_t state_r;
  debounce_state_t state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  logic            out_s;
  logic            rise_s;
  logic            fall_s;

  debouncer_synchronizer #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (bouncy_in),
    .q  (sync_q_s)
  );

  // Next-state, stability counter and output decode.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    out_s   = state_level(state_r);
    rise_s  = 1'b0;
    fall_s  = 1'b0;
    case (state_r)
      S_LOW: begin
        if (sync_q_s) begin
          state_s = S_MAYBE_HIGH;
          cnt_s   = CNT_ONE;
        end else begin
          cnt_s   = '0;
        end
      end
      S_MAYBE_HIGH: begin
        if (!sync_q_s) begin
          state_s = S_LOW;
          cnt_s   = '0;
        end else if (cnt_r == CNT_MAX) begin
          state_s = S_HIGH;
          cnt_s   = '0;
          out_s   = 1'b1;
          rise_s  = 1'b1;
        end else begin
          cnt_s   = cnt_r + CNT_ONE;
        end
      end
      S_HIGH: begin
        if (!sync_q_s) begin
          state_s = S_MAYBE_LOW;
          cnt_s   = CNT_ONE;
        end else begin
          cnt_s   = '0;
        end
      end
      S_MAYBE_LOW: begin
        if (sync_q_s) begin
          state_s = S_HIGH;
          cnt_s   = '0;
        end else if (cnt_r == CNT_MAX) begin
          state_s = S_LOW;
          cnt_s   = '0;
          out_s   = 1'b0;
          fall_s  = 1'b1;
        end else begin
          cnt_s   = cnt_r + CNT_ONE;
        end
      end
      default: begin
        // Corrupted state code: fall back to the safe low level.
        state_s = S_LOW;
        cnt_s   = '0;
        out_s   = 1'b0;
      end
    endcase
  end

  // State, counter and registered outputs all update on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= S_LOW;
      cnt_r         <= '0;
      debounced_out <= 1'b0;
      rise_pulse    <= 1'b0;
      fall_pulse    <= 1'b0;
    end else begin
      state_r       <= state_s;
      cnt_r         <= cnt_s;
      debounced_out <= out_s;
      rise_pulse    <= rise_s;
      fall_pulse    <= fall_s;
    end
  end

  debouncer_checker #(
    .CNT_W  (CNT_W),
    .CNT_MAX(BOUNCE_TICKS)
  ) u_chk (
    .clk          (clk),
    .rst          (rst),
    .debounced_out(debounced_out),
    .rise_pulse   (rise_pulse),
    .fall_pulse   (fall_pulse),
    .cnt          (cnt_r)
  );

endmodule

// File: tb/tb_debouncer.sv
// Self-checking bench for debouncer: scoreboard of expected output transitions
// for BOUNCE_TICKS=100, plus a cycle-exact latency check at BOUNCE_TICKS=1.
`timescale 1ns/100ps
module tb_debouncer;

  localparam int BT  = 100;
  localparam int LAT = BT + 2;

  typedef struct {
    int   edge_no;
    logic level;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic bouncy_in;
  logic debounced_out;
  logic rise_pulse;
  logic fall_pulse;
  logic bouncy1;
  logic out1;
  logic rise1;
  logic fall1;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_diff = 0;
  logic track_level = 1'b0;
  logic prev_out = 1'b0;
  bit   mon_en = 1'b0;

  debouncer #(.BOUNCE_TICKS(BT)) dut (
    .clk(clk), .rst(rst), .bouncy_in(bouncy_in),
    .debounced_out(debounced_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse)
  );

  debouncer #(.BOUNCE_TICKS(1)) dut_bt1 (
    .clk(clk), .rst(rst), .bouncy_in(bouncy1),
    .debounced_out(out1), .rise_pulse(rise1), .fall_pulse(fall1)
  );

  // ~12 MHz clock
  initial forever #42 clk = ~clk;

  // Edge counter; also remembers the last edge that sampled a level other than track_level.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (bouncy_in !== track_level) last_diff = cyc;
  end

  // Scoreboard: every output change or pulse must match the oldest expected event.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (debounced_out !== prev_out || rise_pulse !== 1'b0 || fall_pulse !== 1'b0) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: cycle %0d out=%b rise=%b fall=%b, required no change",
                     cyc, debounced_out, rise_pulse, fall_pulse);
          end else begin
            e = exp_q.pop_front();
            if (cyc !== e.edge_no || debounced_out !== e.level ||
                rise_pulse !== e.level || fall_pulse !== ~e.level) begin
              errors++;
              $display("FAIL event: cycle %0d out=%b rise=%b fall=%b, required cycle %0d out=%b rise=%b fall=%b",
                       cyc, debounced_out, rise_pulse, fall_pulse,
                       e.edge_no, e.level, e.level, ~e.level);
            end
          end
        end
      end
      prev_out = debounced_out;
    end
  end

  initial begin
    #(84 * 20000);
    $display("FAIL watchdog: simulation exceeded 20000 cycles");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v);
    step();
    bouncy_in = v;
  endtask

  task automatic expect_change(input int edge_no, input logic level);
    exp_t e;
    e.edge_no = edge_no;
    e.level   = level;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 3 * LAT && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d events pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_level(input string name, input logic lvl);
    @(negedge clk);
    checks++;
    if (debounced_out !== lvl || rise_pulse !== 1'b0 || fall_pulse !== 1'b0) begin
      errors++;
      $display("FAIL %s_level: out=%b rise=%b fall=%b, required out=%b rise=0 fall=0",
               name, debounced_out, rise_pulse, fall_pulse, lvl);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bouncy_in = 1'b0;
    bouncy1 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (debounced_out !== 1'b0) begin
      errors++; $display("FAIL reset_out: out=%b, required 0", debounced_out);
    end
    checks++;
    if (rise_pulse !== 1'b0 || fall_pulse !== 1'b0) begin
      errors++; $display("FAIL reset_pulses: rise=%b fall=%b, required 0 0", rise_pulse, fall_pulse);
    end
    checks++;
    if (out1 !== 1'b0 || rise1 !== 1'b0 || fall1 !== 1'b0) begin
      errors++; $display("FAIL reset_bt1: out=%b rise=%b fall=%b, required 0 0 0", out1, rise1, fall1);
    end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      checks++;
      if (debounced_out !== 1'b0 || rise_pulse !== 1'b0 || fall_pulse !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle: cycle %0d out=%b rise=%b fall=%b, required 0 0 0",
                 i, debounced_out, rise_pulse, fall_pulse);
      end
    end
    prev_out = debounced_out;
    mon_en = 1'b1;
  endtask

  task automatic test_clean(input logic lvl, input string name);
    drive(lvl);
    expect_change(cyc + 1 + LAT, lvl);
    drain(name);
    check_level(name, lvl);
  endtask

  task automatic test_glitch(input logic lvl, input string name);
    drive(~lvl);
    repeat (99) step();
    bouncy_in = lvl;
    repeat (150) @(negedge clk);
    check_level(name, lvl);
  endtask

  task automatic test_bounce(input logic lvl, input string name);
    int n;
    n = int'($urandom_range(10, 29));
    if (n % 2 == 0) n++;
    track_level = lvl;
    step();
    #0.5;
    for (int i = 0; i < n; i++) begin
      #($urandom_range(1, 15));
      bouncy_in = ~bouncy_in;
    end
    step();
    checks++;
    if (bouncy_in !== lvl) begin
      errors++; $display("FAIL %s_final_level: in=%b, required %b", name, bouncy_in, lvl);
    end
    expect_change(last_diff + 3 + BT, lvl);
    drain(name);
    check_level(name, lvl);
  endtask

  task automatic test_reset_mid();
    int r;
    drive(1'b1);
    repeat (49) step();
    rst = 1'b1;
    r = cyc + 1;
    step();
    rst = 1'b0;
    expect_change(r + 1 + LAT, 1'b1);
    drain("reset_mid");
    check_level("reset_mid", 1'b1);
  endtask

  task automatic test_bt1(input logic lvl, input string name);
    int n;
    step();
    bouncy1 = lvl;
    n = cyc + 1;
    while (cyc < n + 2) @(negedge clk);
    checks++;
    if (out1 !== ~lvl || rise1 !== 1'b0 || fall1 !== 1'b0) begin
      errors++;
      $display("FAIL %s_early: out=%b rise=%b fall=%b, required out=%b rise=0 fall=0",
               name, out1, rise1, fall1, ~lvl);
    end
    @(negedge clk);
    checks++;
    if (out1 !== lvl || rise1 !== lvl || fall1 !== ~lvl) begin
      errors++;
      $display("FAIL %s_edge: out=%b rise=%b fall=%b, required out=%b rise=%b fall=%b",
               name, out1, rise1, fall1, lvl, lvl, ~lvl);
    end
    @(negedge clk);
    checks++;
    if (out1 !== lvl || rise1 !== 1'b0 || fall1 !== 1'b0) begin
      errors++;
      $display("FAIL %s_clear: out=%b rise=%b fall=%b, required out=%b rise=0 fall=0",
               name, out1, rise1, fall1, lvl);
    end
  endtask

  initial begin
    test_reset();
    test_clean(1'b1, "clean_rise");
    test_glitch(1'b1, "glitch_from_high");
    test_clean(1'b0, "fall");
    test_glitch(1'b0, "glitch_from_low");
    test_bounce(1'b1, "bounce_to_high");
    test_bounce(1'b0, "bounce_to_low");
    track_level = 1'b0;
    test_reset_mid();
    test_clean(1'b0, "fall_after_reset");
    test_bt1(1'b1, "bt1_rise");
    test_bt1(1'b0, "bt1_fall");
    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL leftover_events: %0d pending, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
